bp_me_lce_mask_to_cord: RTL and testbench

BP_ME_LCE_MASK_TO_CORD -- requirements
Module: bp_me_lce_mask_to_cord

---
 rtl/bp_me_lce_mask_to_cord.sv | 184 ++++++++++++++++++
 tb/tb_bp_me_lce_mask_to_cord.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bp_me_lce_mask_to_cord.sv
// rtl/bp_me_lce_mask_to_cord.sv - walks an LCE destination mask and emits the mesh cord of every set LCE
package bp_me_lce_mask_to_cord_pkg;
  typedef enum logic [1:0] {e_cce_fsm, e_cce_ucode, e_cce_uce} bp_cce_type_e;

  typedef struct packed {
    bp_cce_type_e cce_type;
    int unsigned  sac_x_dim;
    int unsigned  cc_x_dim;
    int unsigned  cc_y_dim;
    int unsigned  ic_y_dim;
    int unsigned  num_cacc;
    int unsigned  num_l2e;
    int unsigned  num_sacc;
    int unsigned  num_io;
    int unsigned  x_cord_width;
    int unsigned  y_cord_width;
  } bp_proc_param_s;

  localparam bp_proc_param_s e_bp_default_cfg = '{
    cce_type: e_cce_fsm, sac_x_dim: 0, cc_x_dim: 2, cc_y_dim: 2, ic_y_dim: 1,
    num_cacc: 0, num_l2e: 2, num_sacc: 0, num_io: 2, x_cord_width: 4, y_cord_width: 4
  };
endpackage

module bp_me_lce_mask_to_cord
  import bp_me_lce_mask_to_cord_pkg::*;
  #(parameter bp_proc_param_s bp_params_p = e_bp_default_cfg
    , localparam int sac_x_dim_p            = int'(bp_params_p.sac_x_dim)
    , localparam int cc_x_dim_p             = int'(bp_params_p.cc_x_dim)
    , localparam int cc_y_dim_p             = int'(bp_params_p.cc_y_dim)
    , localparam int ic_y_dim_p             = int'(bp_params_p.ic_y_dim)
    , localparam int num_cacc_p             = int'(bp_params_p.num_cacc)
    , localparam int num_l2e_p              = int'(bp_params_p.num_l2e)
    , localparam int num_sacc_p             = int'(bp_params_p.num_sacc)
    , localparam int num_io_p               = int'(bp_params_p.num_io)
    , localparam int num_core_p             = cc_x_dim_p * cc_y_dim_p
    , localparam int num_lce_p              = 2*num_core_p + num_cacc_p + num_l2e_p + num_sacc_p + num_io_p
    , localparam int lce_id_width_p         = (num_lce_p > 1) ? $clog2(num_lce_p) : 1
    , localparam int coh_noc_x_cord_width_p = int'(bp_params_p.x_cord_width)
    , localparam int coh_noc_y_cord_width_p = int'(bp_params_p.y_cord_width)
    , localparam int coh_noc_cord_width_p   = coh_noc_x_cord_width_p + coh_noc_y_cord_width_p
    )
   (input  logic                            clk_i
    , input  logic                          reset_i
    , input  logic [num_lce_p-1:0]          lce_mask_i
    , input  logic                          v_i
    , output logic                          ready_and_o
    , output logic [coh_noc_cord_width_p-1:0] cord_o
    , output logic [lce_id_width_p-1:0]     lce_id_o
    , output logic                          last_o
    , output logic                          v_o
    , input  logic                          ready_and_i
    , output logic                          done_o
    );

  if (bp_params_p.cce_type == e_cce_uce) begin : g_uce_unsupported
    $error("bp_me_lce_mask_to_cord cannot be used in a UCE configuration");
  end

  localparam int id_ext_w_lp = lce_id_width_p + 1;
  typedef logic [id_ext_w_lp-1:0]            id_ext_t;
  typedef logic [lce_id_width_p-1:0]         id_t;
  typedef logic [coh_noc_x_cord_width_p-1:0] x_t;
  typedef logic [coh_noc_y_cord_width_p-1:0] y_t;

  typedef enum logic [1:0] {e_ready, e_scan, e_done} state_e;
  typedef enum logic [2:0] {e_rg_core, e_rg_cacc, e_rg_l2e, e_rg_sacc, e_rg_io} region_e;

  localparam id_ext_t cacc_base_lp = id_ext_t'(2*num_core_p);
  localparam id_ext_t l2e_base_lp  = id_ext_t'(2*num_core_p + num_cacc_p);
  localparam id_ext_t sacc_base_lp = id_ext_t'(2*num_core_p + num_cacc_p + num_l2e_p);
  localparam id_ext_t io_base_lp   = id_ext_t'(2*num_core_p + num_cacc_p + num_l2e_p + num_sacc_p);
  localparam id_t     last_idx_lp  = id_t'(num_lce_p - 1);
  localparam x_t      core_x_max_lp = x_t'(sac_x_dim_p + cc_x_dim_p - 1);

  // Empty regions collapse to zero-width id ranges and are skipped naturally.
  function automatic region_e region_of(id_ext_t id);
    if (id < cacc_base_lp)      return e_rg_core;
    else if (id < l2e_base_lp)  return e_rg_cacc;
    else if (id < sacc_base_lp) return e_rg_l2e;
    else if (id < io_base_lp)   return e_rg_sacc;
    else                        return e_rg_io;
  endfunction

  function automatic x_t region_x0(region_e rg);
    case (rg)
      e_rg_cacc: return x_t'(sac_x_dim_p + cc_x_dim_p);
      e_rg_sacc: return '0;
      default:   return x_t'(sac_x_dim_p);
    endcase
  endfunction

  function automatic y_t region_y0(region_e rg);
    case (rg)
      e_rg_l2e: return y_t'(ic_y_dim_p + cc_y_dim_p);
      e_rg_io:  return '0;
      default:  return y_t'(ic_y_dim_p);
    endcase
  endfunction

  state_e               state_r, state_n;
  logic [num_lce_p-1:0] mask_r, mask_n;
  id_t                  idx_r, idx_n;
  x_t                   x_r, x_n;
  y_t                   y_r, y_n;

  id_ext_t              idx_ext, idx_nxt_ext;
  region_e              rg_cur, rg_nxt;
  logic [num_lce_p-1:0] mask_above;

  assign idx_ext     = {1'b0, idx_r};
  assign idx_nxt_ext = idx_ext + id_ext_t'(1);
  assign rg_cur      = region_of(idx_ext);
  assign rg_nxt      = region_of(idx_nxt_ext);
  assign mask_above  = mask_r >> idx_nxt_ext;

  assign ready_and_o = (state_r == e_ready);
  assign done_o      = (state_r == e_done);
  assign v_o         = (state_r == e_scan) & mask_r[idx_r];
  assign last_o      = v_o & ~(|mask_above);
  assign lce_id_o    = idx_r;
  assign cord_o      = {y_r, x_r};

  always_comb begin
    state_n = state_r;
    mask_n  = mask_r;
    idx_n   = idx_r;
    x_n     = x_r;
    y_n     = y_r;
    case (state_r)
      e_ready: if (v_i) begin
        state_n = e_scan;
        mask_n  = lce_mask_i;
        idx_n   = '0;
        x_n     = region_x0(region_of('0));
        y_n     = region_y0(region_of('0));
      end
      e_scan: if (~mask_r[idx_r] | ready_and_i) begin
        if (idx_r == last_idx_lp) begin
          state_n = e_done;
        end else begin
          idx_n = idx_nxt_ext[lce_id_width_p-1:0];
          if (rg_nxt != rg_cur) begin
            x_n = region_x0(rg_nxt);
            y_n = region_y0(rg_nxt);
          end else begin
            case (rg_cur)
              // Two LCEs per core: the tile moves only when leaving an odd id.
              e_rg_core: if (idx_r[0]) begin
                if (x_r == core_x_max_lp) begin
                  x_n = x_t'(sac_x_dim_p);
                  y_n = y_r + y_t'(1);
                end else begin
                  x_n = x_r + x_t'(1);
                end
              end
              e_rg_cacc, e_rg_sacc: y_n = y_r + y_t'(1);
              default:              x_n = x_r + x_t'(1);
            endcase
          end
        end
      end
      e_done:  state_n = e_ready;
      default: state_n = e_ready;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_ready;
      mask_r  <= '0;
      idx_r   <= '0;
      x_r     <= '0;
      y_r     <= '0;
    end else begin
      state_r <= state_n;
      mask_r  <= mask_n;
      idx_r   <= idx_n;
      x_r     <= x_n;
      y_r     <= y_n;
    end
  end

endmodule

// File: tb/tb_bp_me_lce_mask_to_cord.sv
// tb/tb_bp_me_lce_mask_to_cord.sv - scoreboard bench for the LCE mask to cord walker
module tb_bp_me_lce_mask_to_cord;
  localparam int n_lce  = 12;
  localparam int sac_x  = 0;
  localparam int cc_x   = 2;
  localparam int cc_y   = 2;
  localparam int ic_y   = 1;
  localparam int n_cacc = 0;
  localparam int n_l2e  = 2;
  localparam int n_sacc = 0;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [n_lce-1:0]  lce_mask_i;
  logic              v_i;
  logic              ready_and_o;
  logic [7:0]        cord_o;
  logic [3:0]        lce_id_o;
  logic              last_o;
  logic              v_o;
  logic              ready_and_i;
  logic              done_o;

  int checks = 0;
  int errors = 0;
  int cur_cyc = 0;

  typedef struct {
    int         first;
    int         acc;
    int         lce;
    logic [7:0] cord;
    logic       last;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  bp_me_lce_mask_to_cord dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .lce_mask_i  (lce_mask_i),
    .v_i         (v_i),
    .ready_and_o (ready_and_o),
    .cord_o      (cord_o),
    .lce_id_o    (lce_id_o),
    .last_o      (last_o),
    .v_o         (v_o),
    .ready_and_i (ready_and_i),
    .done_o      (done_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cur_cyc, obs, exp);
    end
  endtask

  // Reference cord by direct division/modulo over the LCE id regions.
  function automatic logic [7:0] model_cord(input int l);
    int x, y, k, c;
    int cacc_b, l2e_b, sacc_b, io_b;
    cacc_b = 2*cc_x*cc_y;
    l2e_b  = cacc_b + n_cacc;
    sacc_b = l2e_b + n_l2e;
    io_b   = sacc_b + n_sacc;
    if (l < cacc_b) begin
      c = l / 2; x = sac_x + c % cc_x; y = ic_y + c / cc_x;
    end else if (l < l2e_b) begin
      k = l - cacc_b; x = sac_x + cc_x; y = ic_y + k;
    end else if (l < sacc_b) begin
      k = l - l2e_b; x = sac_x + k; y = ic_y + cc_y;
    end else if (l < io_b) begin
      k = l - sacc_b; x = 0; y = ic_y + k;
    end else begin
      k = l - io_b; x = sac_x + k; y = 0;
    end
    return {y[3:0], x[3:0]};
  endfunction

  task automatic chk_reset_values();
    chk("rst_v_o", 32'(v_o), 32'(0));
    chk("rst_ready_and_o", 32'(ready_and_o), 32'(1));
    chk("rst_done_o", 32'(done_o), 32'(0));
    chk("rst_cord_o", 32'(cord_o), 32'(0));
    chk("rst_lce_id_o", 32'(lce_id_o), 32'(0));
    chk("rst_last_o", 32'(last_o), 32'(0));
  endtask

  // stall[t]=1 holds ready_and_i low in cycle t; inj pulses v_i with 0x004; abort resets in that cycle.
  task automatic run_scan(input logic [n_lce-1:0] mask, input logic [63:0] stall,
                          input int inj, input int abort);
    int   t, done_cyc;
    exp_t e;
    logic exp_v;
    sb.delete();
    t = 1;
    for (int l = 0; l < n_lce; l++) begin
      if (mask[l]) begin
        e.first = t;
        while (stall[t] && t < 60) t++;
        e.acc  = t;
        e.lce  = l;
        e.cord = model_cord(l);
        e.last = ((mask >> (l + 1)) == 0);
        sb.push_back(e);
      end
      t++;
    end
    done_cyc = t;

    for (int cyc = 0; cyc <= done_cyc + 1; cyc++) begin
      cur_cyc     = cyc;
      v_i         = (cyc == 0) || (cyc == inj);
      lce_mask_i  = (cyc == inj) ? 12'h004 : mask;
      ready_and_i = ~stall[cyc];
      if (cyc == abort) begin
        reset_i = 1'b1;
        #1;
        chk_reset_values();
        @(negedge clk);
        reset_i = 1'b0;
        @(posedge clk);
        #1;
        v_i = 1'b0;
        sb.delete();
        return;
      end
      @(negedge clk);
      exp_v = (sb.size() > 0) && (sb[0].first <= cyc);
      chk("v_o", 32'(v_o), 32'(exp_v));
      if (v_o && exp_v) begin
        chk("lce_id_o", 32'(lce_id_o), 32'(sb[0].lce));
        chk("cord_o", 32'(cord_o), 32'(sb[0].cord));
        chk("last_o", 32'(last_o), 32'(sb[0].last));
      end
      if (sb.size() > 0 && sb[0].acc == cyc) void'(sb.pop_front());
      chk("done_o", 32'(done_o), 32'(cyc == done_cyc));
      chk("ready_and_o", 32'(ready_and_o), 32'((cyc == 0) || (cyc > done_cyc)));
      @(posedge clk);
      #1;
    end
    v_i = 1'b0;
    chk("sb_drained", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    reset_i     = 1'b1;
    v_i         = 1'b0;
    ready_and_i = 1'b1;
    lce_mask_i  = '0;
    @(posedge clk);
    #1;
    chk_reset_values();
    @(negedge clk);
    reset_i = 1'b0;
    @(posedge clk);
    #1;

    run_scan(12'h001, 64'h0, -1, -1);
    run_scan(12'h921, 64'h0, -1, -1);
    run_scan(12'h003, 64'hE, -1, -1);
    run_scan(12'h000, 64'h0, -1, -1);
    run_scan(12'hFFF, 64'h0, -1, 5);
    run_scan(12'h800, 64'h0, -1, -1);
    run_scan(12'h0A1, 64'h0, 3, -1);
    run_scan(12'hFFF, 64'h0000_0000_0005_5A54, -1, -1);
    for (int r = 0; r < 4; r++) begin
      logic [63:0] st;
      st = {$urandom, $urandom} & {$urandom, $urandom};
      run_scan(12'($urandom), st & 64'h0000_00FF_FFFF_FFFE, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
